// File: rtl/compositor_quadros_pkg.sv
// Shared tables for the OLED frame compositor: animation states, playback modes,
// per-state frame count / ROM base, status-bar rows and overlay byte patterns.
// Contents: modo_t, state indices, NQ/MODO/BASE/R0 tables, byte_barra(), tabelas_ok().
package pkg_quadros;

   localparam int BYTES_QUADRO_P = 1024;
   localparam int N_ESTADOS_P    = 5;
   localparam int MAX_QUADROS_P  = 8;
   localparam int N_BARRAS_P     = 3;
   localparam int DIV_QUADRO_P   = 8388608;
   localparam int LARG_MEM_P     = 16;

   typedef enum logic [1:0] {
      LOOP     = 2'd0,
      PINGPONG = 2'd1,
      ONESHOT  = 2'd2
   } modo_t;

   localparam int IDLE       = 0;
   localparam int DORMINDO   = 1;
   localparam int COMENDO    = 2;
   localparam int DANDO_AULA = 3;
   localparam int MORTO      = 4;

   localparam int    NQ   [N_ESTADOS_P] = '{6, 4, 5, 8, 1};
   localparam modo_t MODO [N_ESTADOS_P] = '{LOOP, PINGPONG, ONESHOT, LOOP, PINGPONG};

   // Frames of all states are packed back to back in the ROM.
   function automatic int base_de(input int e);
      int soma;
      soma = 0;
      for (int i = 0; i < e; i++) soma += NQ[i] * BYTES_QUADRO_P;
      return soma;
   endfunction

   localparam int BASE [N_ESTADOS_P] = '{base_de(0), base_de(1), base_de(2), base_de(3), base_de(4)};

   // First row of each 5-row status bar.
   localparam int R0 [N_BARRAS_P] = '{8, 16, 24};

   localparam logic [7:0] BYTE_CHEIO = 8'hEE;
   localparam logic [7:0] BYTE_VAZIO = 8'h00;
   localparam logic [7:0] BYTE_MEIO  = 8'hE0;

   // Column c (1..5) of a bar covers levels 100-20c .. 110-20c: above the top
   // it is fully lit, in between half lit. Levels above 100 saturate.
   function automatic logic [7:0] byte_barra(input logic [6:0] nivel, input logic [2:0] col);
      logic [7:0] l;
      logic [7:0] lim_cheio;
      logic [7:0] lim_meio;
      l         = (nivel > 7'd100) ? 8'd100 : {1'b0, nivel};
      lim_cheio = 8'd110 - 8'd20 * {5'd0, col};
      lim_meio  = 8'd100 - 8'd20 * {5'd0, col};
      if (l > lim_cheio)     byte_barra = BYTE_CHEIO;
      else if (l > lim_meio) byte_barra = BYTE_MEIO;
      else                   byte_barra = BYTE_VAZIO;
   endfunction

   // Table consistency: frames fit the ROM, bars fit the frame and never overlap.
   function automatic bit tabelas_ok(input int larg_mem);
      bit ok;
      ok = 1'b1;
      if ((BYTES_QUADRO_P & (BYTES_QUADRO_P - 1)) != 0) ok = 1'b0;
      for (int e = 0; e < N_ESTADOS_P; e++) begin
         if (NQ[e] < 1 || NQ[e] > MAX_QUADROS_P) ok = 1'b0;
         if (longint'(base_de(e)) + longint'(NQ[e]) * BYTES_QUADRO_P > (longint'(1) << larg_mem))
            ok = 1'b0;
      end
      for (int k = 0; k < N_BARRAS_P; k++) begin
         if (R0[k] + 4 >= BYTES_QUADRO_P / 8) ok = 1'b0;
         for (int j = 0; j < k; j++)
            if (R0[j] <= R0[k] + 4 && R0[k] <= R0[j] + 4) ok = 1'b0;
      end
      return ok;
   endfunction

endpackage

// File: rtl/compositor_quadros_sequenciador.sv
// Animation tick divider plus per-state frame index, ping-pong direction and one-shot end flag.
// Latency: state/frame update on the clock edge that accepts a boundary request; no backpressure.
// Ports: i_fronteira (addr-0 request accepted), i_estado (requested state) -> o_estado_ativo, o_quadro, o_fim.
module sequenciador_quadro
   import pkg_quadros::*;
#(
   parameter  int N_ESTADOS   = N_ESTADOS_P,
   parameter  int MAX_QUADROS = MAX_QUADROS_P,
   parameter  int DIV_QUADRO  = DIV_QUADRO_P,
   localparam int LE          = $clog2(N_ESTADOS),
   localparam int LQ          = $clog2(MAX_QUADROS),
   localparam int LC          = (DIV_QUADRO > 1) ? $clog2(DIV_QUADRO) : 1
)
(
   input  logic          i_clk,
   input  logic          i_rst_n,
   input  logic          i_fronteira,
   input  logic [LE-1:0] i_estado,
   output logic [LE-1:0] o_estado_ativo,
   output logic [LQ-1:0] o_quadro,
   output logic          o_fim
);

   logic [LC-1:0] r_cont;
   logic          r_pend;
   logic [LE-1:0] r_ativo;
   logic [LQ-1:0] r_quadro;
   logic          r_desce;
   logic          r_fim;

   logic          w_tick;
   logic          w_troca;
   logic [LQ-1:0] w_ult;
   modo_t         w_modo;
   logic [LQ-1:0] w_prox;
   logic          w_prox_desce;
   logic          w_prox_fim;

   assign w_tick  = (r_cont == LC'(DIV_QUADRO - 1));
   // Out-of-range state requests are ignored, so they never count as a change.
   assign w_troca = (i_estado != r_ativo) && (int'(i_estado) < N_ESTADOS);
   assign w_ult   = LQ'(NQ[r_ativo] - 1);
   assign w_modo  = MODO[r_ativo];

   always_comb begin
      w_prox       = r_quadro;
      w_prox_desce = r_desce;
      w_prox_fim   = r_fim;
      case (w_modo)
         LOOP: begin
            w_prox = (r_quadro == w_ult) ? '0 : r_quadro + LQ'(1);
         end
         PINGPONG: begin
            // Endpoints are visited once: turn around on the step that leaves them.
            if (w_ult == '0) begin
               w_prox       = '0;
               w_prox_desce = 1'b0;
            end else if (!r_desce) begin
               if (r_quadro == w_ult) begin
                  w_prox       = r_quadro - LQ'(1);
                  w_prox_desce = 1'b1;
               end else begin
                  w_prox = r_quadro + LQ'(1);
               end
            end else begin
               if (r_quadro == '0) begin
                  w_prox       = LQ'(1);
                  w_prox_desce = 1'b0;
               end else begin
                  w_prox = r_quadro - LQ'(1);
               end
            end
         end
         ONESHOT: begin
            w_prox     = (r_quadro == w_ult) ? r_quadro : r_quadro + LQ'(1);
            w_prox_fim = (w_prox == w_ult);
         end
         default: ;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_cont   <= '0;
         r_pend   <= 1'b0;
         r_ativo  <= '0;
         r_quadro <= '0;
         r_desce  <= 1'b0;
         r_fim    <= 1'b0;
      end else begin
         r_cont <= w_tick ? '0 : r_cont + LC'(1);

         if (i_fronteira && w_troca) begin
            r_ativo  <= i_estado;
            r_quadro <= '0;
            r_desce  <= 1'b0;
            r_fim    <= 1'b0;
         end else if (i_fronteira && r_pend) begin
            r_quadro <= w_prox;
            r_desce  <= w_prox_desce;
            r_fim    <= w_prox_fim;
         end

         // A tick landing on a boundary edge survives for the following boundary.
         if (w_tick)
            r_pend <= 1'b1;
         else if (i_fronteira && (w_troca || r_pend))
            r_pend <= 1'b0;
      end
   end

   assign o_estado_ativo = r_ativo;
   assign o_quadro       = r_quadro;
   assign o_fim          = r_fim;

endmodule

// File: rtl/compositor_quadros.sv
// Streams OLED frame bytes: ROM animation frame with status bars composed on top.
// Latency 3 cycles req -> o_dado_valido, one request per cycle, no backpressure.
// Ports: i_req/i_byte_addr/i_estado/i_niveis in; o_mem_addr -> i_mem_data ROM loop; o_data_to_send/o_dado_valido/o_fim_animacao out.
module compositor_quadros
   import pkg_quadros::*;
#(
   parameter  int BYTES_QUADRO = BYTES_QUADRO_P,
   parameter  int N_ESTADOS    = N_ESTADOS_P,
   parameter  int MAX_QUADROS  = MAX_QUADROS_P,
   parameter  int N_BARRAS     = N_BARRAS_P,
   parameter  int DIV_QUADRO   = DIV_QUADRO_P,
   parameter  int LARG_MEM     = LARG_MEM_P,
   localparam int LE           = $clog2(N_ESTADOS),
   localparam int LB           = $clog2(BYTES_QUADRO)
)
(
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic [LE-1:0]         i_estado,
   input  logic                  i_req,
   input  logic [LB-1:0]         i_byte_addr,
   input  logic [N_BARRAS*7-1:0] i_niveis,
   output logic [LARG_MEM-1:0]   o_mem_addr,
   input  logic [7:0]            i_mem_data,
   output logic [7:0]            o_data_to_send,
   output logic                  o_dado_valido,
   output logic                  o_fim_animacao
);

   localparam int LQ = $clog2(MAX_QUADROS);
   localparam int LL = LB - 3;

   if (!tabelas_ok(LARG_MEM) || BYTES_QUADRO != BYTES_QUADRO_P || N_ESTADOS != N_ESTADOS_P ||
       MAX_QUADROS != MAX_QUADROS_P || N_BARRAS != N_BARRAS_P) begin : g_cfg_invalida
      $error("compositor_quadros: parameters disagree with pkg_quadros tables");
   end

   logic                w_fronteira;
   logic [LE-1:0]       w_ativo;
   logic [LQ-1:0]       w_quadro;
   logic [LARG_MEM-1:0] w_addr;
   logic [LL-1:0]       w_lin;
   logic [2:0]          w_col;
   logic                w_ov;
   logic [7:0]          w_ovb;

   logic                r_v1;
   logic [LB-1:0]       r_ba1;
   logic                r_v2;
   logic                r_ov2;
   logic [7:0]          r_ovb2;
   logic                r_v3;
   logic                r_ov3;
   logic [7:0]          r_ovb3;

   assign w_fronteira = i_req && (i_byte_addr == '0);

   // Boundary handling happens on the request edge, so the address formed on
   // the next edge already sees the new state/frame.
   sequenciador_quadro #(
      .N_ESTADOS   (N_ESTADOS),
      .MAX_QUADROS (MAX_QUADROS),
      .DIV_QUADRO  (DIV_QUADRO)
   ) u_seq (
      .i_clk          (i_clk),
      .i_rst_n        (i_rst_n),
      .i_fronteira    (w_fronteira),
      .i_estado       (i_estado),
      .o_estado_ativo (w_ativo),
      .o_quadro       (w_quadro),
      .o_fim          (o_fim_animacao)
   );

   assign w_addr = LARG_MEM'(BASE[w_ativo])
                 + LARG_MEM'(w_quadro) * LARG_MEM'(BYTES_QUADRO)
                 + LARG_MEM'(r_ba1);

   always_comb begin
      w_ov  = 1'b0;
      w_ovb = BYTE_VAZIO;
      w_lin = r_ba1[LB-1:3];
      w_col = r_ba1[2:0];
      for (int k = 0; k < N_BARRAS; k++) begin
         if (w_lin >= LL'(R0[k]) && w_lin <= LL'(R0[k] + 4) && w_col >= 3'd1 && w_col <= 3'd5) begin
            w_ov  = 1'b1;
            w_ovb = byte_barra(i_niveis[7*k +: 7], w_col);
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_v1           <= 1'b0;
         r_ba1          <= '0;
         r_v2           <= 1'b0;
         r_ov2          <= 1'b0;
         r_ovb2         <= '0;
         r_v3           <= 1'b0;
         r_ov3          <= 1'b0;
         r_ovb3         <= '0;
         o_mem_addr     <= '0;
         o_data_to_send <= '0;
         o_dado_valido  <= 1'b0;
      end else begin
         r_v1 <= i_req;
         if (i_req) r_ba1 <= i_byte_addr;

         r_v2 <= r_v1;
         if (r_v1) begin
            o_mem_addr <= w_addr;
            r_ov2      <= w_ov;
            r_ovb2     <= w_ovb;
         end

         // Overlay decision rides alongside the ROM read cycle.
         r_v3   <= r_v2;
         r_ov3  <= r_ov2;
         r_ovb3 <= r_ovb2;

         o_dado_valido <= r_v3;
         if (r_v3) o_data_to_send <= r_ov3 ? r_ovb3 : i_mem_data;
      end
   end

endmodule

// File: doc/compositor_quadros.md
Name: compositor_quadros

Overview:
Parametrised successor to the single-purpose image controller. It streams 1024-byte OLED frames, byte by byte, to the display driver. Each frame is an animation frame fetched from an external synchronous ROM, with N_BARRAS status bars overlaid on top. Per-state frame count, ROM base and playback mode (LOOP / PINGPONG / ONESHOT) come from a shared package. Frame and state changes take effect only at frame boundaries, so no tearing.

Parameters:
BYTES_QUADRO, 1024, bytes per frame (power of two)
N_ESTADOS, 5, number of animation states
MAX_QUADROS, 8, max frames per state
N_BARRAS, 3, number of overlaid status bars
DIV_QUADRO, 8388608, clk cycles per animation tick
LARG_MEM, 16, ROM address width

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
estado  in  $clog2(N_ESTADOS)  requested animation state, binary index
req  in  1  byte request valid; one per cycle allowed
byte_addr  in  $clog2(BYTES_QUADRO)  byte index in frame (row*8+col)
niveis  in  N_BARRAS*7  bar levels, 0..100, bar k at bits [7k+6:7k]
mem_addr  out  LARG_MEM  ROM read address (registered)
mem_data  in  8  ROM data, valid one cycle after mem_addr
data_to_send  out  8  composed byte
dado_valido  out  1  data_to_send valid strobe
fim_animacao  out  1  ONESHOT state reached its last frame

Behaviour:
- Reset values: data_to_send=0, dado_valido=0, mem_addr=0, fim_animacao=0, tick counter=0, tick_pendente=0, quadro=0, direction=up, estado_ativo=0.
- Pipeline, latency 3, full throughput.
  - Edge t: req sampled.
  - Edge t+1: mem_addr = BASE[estado_ativo] + quadro*BYTES_QUADRO + byte_addr. Overlay flag and overlay byte registered.
  - Edge t+2: mem_data captured.
  - Edge t+3: data_to_send = overlay ? overlay byte : mem_data. dado_valido=1 for exactly one cycle per req.
  - Back-to-back reqs produce back-to-back strobes. A cycle without req produces no strobe.
- Tick: 23-bit-class counter wraps at DIV_QUADRO-1 and sets tick_pendente.
- Frame boundary = accepted req with byte_addr==0. At a boundary, estado_ativo and quadro update before the address for that req is formed.
  - If estado != estado_ativo: estado_ativo=estado, quadro=0, direction=up, fim_animacao=0, tick_pendente cleared.
  - Else if tick_pendente: advance quadro per mode, then clear tick_pendente.
  - A tick arriving on the same cycle as a boundary is kept pending for the next boundary.
- Modes, with N = NQ[estado_ativo]:
  - LOOP: 0..N-1, then wraps to 0.
  - PINGPONG: 0,1,..,N-1,N-2,..,1,0,1,... Endpoints are not repeated. N=1 stays at 0.
  - ONESHOT: advances to N-1 and holds; fim_animacao=1 from that boundary until the next state change.
- Bar overlay: bar k covers rows R0[k]..R0[k]+4 (package), columns c=1..5. Byte index = row*8+c.
  - Level L = min(niveis_k, 100).
  - L > 110-20c → 8'hEE; else L > 100-20c → 8'hE0; else 8'h00.
  - All other bytes pass mem_data through.
  - Bar rows must not overlap (package assertion). Levels are sampled at edge t+1.
- estado >= N_ESTADOS is ignored; estado_ativo is kept.
- Reset mid-frame: pipeline flushed, no strobe for in-flight reqs, restart at quadro 0 of state 0.
- All address arithmetic is done at LARG_MEM width without truncation. Package assertion: BASE+NQ*BYTES_QUADRO <= 2^LARG_MEM.

Decomposition:
- Package pkg_quadros: mode enum (LOOP, PINGPONG, ONESHOT); state indices (IDLE, DORMINDO, COMENDO, DANDO_AULA, MORTO); per-state tables NQ[], MODO[], BASE[] (BASE = prefix sum of NQ*BYTES_QUADRO); bar row table R0[]; overlay byte constants 8'hEE / 8'h00 / 8'hE0.
- One sub-module, sequenciador_quadro: tick divider plus per-state frame index / direction / ONESHOT logic, with boundary input and quadro/fim outputs.
- Overlay compare and the address/data pipeline stay in the top level.

Test Plan:
- Reset, then reqs for addr 0..1023 in state IDLE (LOOP, N=6, BASE=0) → mem_addr 0..1023; each data_to_send equals ROM byte 3 cycles after its req; exactly 1024 strobes.
- DIV_QUADRO=16, LOOP N=6, repeated frames → quadro sequence 0,1,2,3,4,5,0. A tick mid-frame changes nothing until the next addr-0 req.
- PINGPONG N=4 → quadro sequence 0,1,2,3,2,1,0,1. ONESHOT N=5 → 0..4 then hold at 4, fim_animacao=1; switching estado clears fim_animacao and quadro=0 at the next boundary.
- niveis bar0=34 → bytes 65/66/67/68/69 read 00,00,00,EE,EE, and bytes 73..77 identical; niveis=85 → byte 65 reads E0; niveis=127 → treated as 100, byte 65 reads EE.
- Gapped req pattern (1 on, 2 off) → strobes follow the same pattern with latency 3. Assert rst_n low with 2 reqs in flight → no strobes; all outputs at reset values asynchronously.
